// File: rtl/pwm_duty_sequencer.sv
// Builds the 4-bit duty word for pwm_generator (static, triangle or sawtooth) in lock-step with its 16-clock frame.
// All outputs registered; duty only moves on frame boundaries; enable=0 freezes every counter and output pulse.
module pwm_duty_sequencer #(
    parameter int STEP_FRAMES = 4,
    parameter int HOLD_FRAMES = 8,
    parameter int DUTY_MIN    = 0,
    parameter int DUTY_MAX    = 15
) (
    input  logic       clk_3125KHz,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] mode,
    input  logic [3:0] static_duty,
    output logic [3:0] duty_cycle,
    output logic       frame_start,
    output logic       ramp_dir,
    output logic       cycle_done
);

    localparam int SW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam int HW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_FRAMES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES);
    localparam logic [3:0]    D_MIN     = 4'(DUTY_MIN);
    localparam logic [3:0]    D_MAX     = 4'(DUTY_MAX);

    typedef enum logic [2:0] {
        ST_IDLE, ST_STATIC, ST_RAMP_UP, ST_HOLD_TOP, ST_RAMP_DOWN, ST_HOLD_BOT
    } state_t;

    state_t          state, state_nxt, cur;
    logic [3:0]      frame_cnt;
    logic [3:0]      duty_nxt;
    logic [SW-1:0]   step_cnt, step_nxt;
    logic [HW-1:0]   hold_cnt, hold_nxt;
    logic            dir_nxt, done_evt;
    logic            boundary, ramp_mode, saw_mode;
    logic            fs_d, cd_d;

    assign boundary  = enable && (frame_cnt == 4'd15);
    assign ramp_mode = (mode == 2'b01) || (mode == 2'b10);
    assign saw_mode  = (mode == 2'b10);

    always_ff @(posedge clk_3125KHz) begin
        if (reset) begin
            state       <= ST_IDLE;
            frame_cnt   <= '0;
            step_cnt    <= '0;
            hold_cnt    <= '0;
            duty_cycle  <= '0;
            frame_start <= 1'b0;
            ramp_dir    <= 1'b1;
            cycle_done  <= 1'b0;
        end else if (enable) begin
            frame_cnt   <= frame_cnt + 4'd1;
            state       <= state_nxt;
            step_cnt    <= step_nxt;
            hold_cnt    <= hold_nxt;
            duty_cycle  <= duty_nxt;
            ramp_dir    <= dir_nxt;
            frame_start <= fs_d;
            cycle_done  <= cd_d;
        end else begin
            frame_start <= 1'b0;
            cycle_done  <= 1'b0;
        end
    end

    // One boundary may chain: normalise state, leave a hold, then take a ramp step.
    always_comb begin
        cur       = state;
        state_nxt = state;
        duty_nxt  = duty_cycle;
        step_nxt  = step_cnt;
        hold_nxt  = hold_cnt;
        dir_nxt   = ramp_dir;
        done_evt  = 1'b0;
        if (boundary) begin
            if (!ramp_mode) begin
                cur      = ST_STATIC;
                duty_nxt = static_duty;
                step_nxt = '0;
                hold_nxt = '0;
            end else begin
                if (cur == ST_IDLE || cur == ST_STATIC) begin
                    cur      = ST_RAMP_UP;
                    dir_nxt  = 1'b1;
                    step_nxt = '0;
                    hold_nxt = '0;
                    if (int'(duty_cycle) < DUTY_MIN)
                        duty_nxt = D_MIN;
                    else if (int'(duty_cycle) > DUTY_MAX)
                        duty_nxt = D_MAX;
                end else if (saw_mode && cur != ST_RAMP_UP) begin
                    cur      = ST_RAMP_UP;
                    dir_nxt  = 1'b1;
                    hold_nxt = '0;
                end

                if (cur == ST_HOLD_TOP) begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_nxt = '0;
                        cur      = ST_RAMP_DOWN;
                        dir_nxt  = 1'b0;
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end else if (cur == ST_HOLD_BOT) begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_nxt = '0;
                        cur      = ST_RAMP_UP;
                        dir_nxt  = 1'b1;
                        done_evt = 1'b1;
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end

                if (cur == ST_RAMP_UP) begin
                    if (saw_mode) begin
                        if (step_nxt == STEP_LAST) begin
                            step_nxt = '0;
                            if (int'(duty_nxt) >= DUTY_MAX) begin
                                duty_nxt = D_MIN;
                                done_evt = 1'b1;
                            end else begin
                                duty_nxt = duty_nxt + 4'd1;
                            end
                        end else begin
                            step_nxt = step_nxt + 1'b1;
                        end
                    end else if (int'(duty_nxt) >= DUTY_MAX || step_nxt == STEP_LAST) begin
                        if (int'(duty_nxt) < DUTY_MAX) begin
                            step_nxt = '0;
                            duty_nxt = duty_nxt + 4'd1;
                        end
                        if (int'(duty_nxt) >= DUTY_MAX) begin
                            if (HOLD_FRAMES == 0) begin
                                cur     = ST_RAMP_DOWN;
                                dir_nxt = 1'b0;
                            end else begin
                                cur      = ST_HOLD_TOP;
                                hold_nxt = '0;
                            end
                        end
                    end else begin
                        step_nxt = step_nxt + 1'b1;
                    end
                end else if (cur == ST_RAMP_DOWN) begin
                    if (int'(duty_nxt) <= DUTY_MIN || step_nxt == STEP_LAST) begin
                        if (int'(duty_nxt) > DUTY_MIN) begin
                            step_nxt = '0;
                            duty_nxt = duty_nxt - 4'd1;
                        end
                        if (int'(duty_nxt) <= DUTY_MIN) begin
                            if (HOLD_FRAMES == 0) begin
                                cur      = ST_RAMP_UP;
                                dir_nxt  = 1'b1;
                                done_evt = 1'b1;
                            end else begin
                                cur      = ST_HOLD_BOT;
                                hold_nxt = '0;
                            end
                        end
                    end else begin
                        step_nxt = step_nxt + 1'b1;
                    end
                end
            end
            state_nxt = cur;
        end
    end

    always_comb begin
        fs_d = (frame_cnt == 4'd15);
        cd_d = boundary && done_evt;
    end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Drives four differently parameterised sequencers from shared inputs; directed profile tables plus a random run against a frame-level model.
module tb_pwm_duty_sequencer;

    localparam int NI = 4;
    localparam int PH_IDLE = 0, PH_STATIC = 1, PH_UP = 2, PH_TOP = 3, PH_DOWN = 4, PH_BOT = 5;

    logic       clk_3125KHz = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] static_duty = 4'd0;
    logic [3:0] duty [NI];
    logic       fs [NI];
    logic       dir [NI];
    logic       cd [NI];

    int checks = 0;
    int errors = 0;

    int p_step [NI] = '{1, 2, 4, 3};
    int p_hold [NI] = '{2, 0, 8, 1};
    int p_min  [NI] = '{0, 0, 0, 3};
    int p_max  [NI] = '{3, 2, 15, 12};

    int m_ph [NI], m_duty [NI], m_frame [NI], m_step [NI], m_hold [NI];
    int m_dir [NI], m_fs [NI], m_cd [NI];

    int tri_tab [12] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, 0, 0, 1};
    int saw_tab [9]  = '{0, 0, 1, 1, 2, 2, 0, 0, 1};

    always #5 clk_3125KHz = ~clk_3125KHz;

    pwm_duty_sequencer #(.STEP_FRAMES(1), .HOLD_FRAMES(2), .DUTY_MIN(0), .DUTY_MAX(3)) u_tri (
        .clk_3125KHz(clk_3125KHz), .reset(reset), .enable(enable), .mode(mode), .static_duty(static_duty),
        .duty_cycle(duty[0]), .frame_start(fs[0]), .ramp_dir(dir[0]), .cycle_done(cd[0]));
    pwm_duty_sequencer #(.STEP_FRAMES(2), .HOLD_FRAMES(0), .DUTY_MIN(0), .DUTY_MAX(2)) u_saw (
        .clk_3125KHz(clk_3125KHz), .reset(reset), .enable(enable), .mode(mode), .static_duty(static_duty),
        .duty_cycle(duty[1]), .frame_start(fs[1]), .ramp_dir(dir[1]), .cycle_done(cd[1]));
    pwm_duty_sequencer u_def (
        .clk_3125KHz(clk_3125KHz), .reset(reset), .enable(enable), .mode(mode), .static_duty(static_duty),
        .duty_cycle(duty[2]), .frame_start(fs[2]), .ramp_dir(dir[2]), .cycle_done(cd[2]));
    pwm_duty_sequencer #(.STEP_FRAMES(3), .HOLD_FRAMES(1), .DUTY_MIN(3), .DUTY_MAX(12)) u_mid (
        .clk_3125KHz(clk_3125KHz), .reset(reset), .enable(enable), .mode(mode), .static_duty(static_duty),
        .duty_cycle(duty[3]), .frame_start(fs[3]), .ramp_dir(dir[3]), .cycle_done(cd[3]));

    // Reference: one call per frame boundary, phrased as the profile rules.
    function automatic void at_top(int i);
        if (p_hold[i] == 0) begin m_ph[i] = PH_DOWN; m_dir[i] = 0; end
        else begin m_ph[i] = PH_TOP; m_hold[i] = 0; end
    endfunction

    function automatic void at_bottom(int i);
        if (p_hold[i] == 0) begin m_ph[i] = PH_UP; m_dir[i] = 1; m_cd[i] = 1; end
        else begin m_ph[i] = PH_BOT; m_hold[i] = 0; end
    endfunction

    function automatic void model_frame(int i, int md, int sd);
        bit saw;
        bit step_due;
        if (md == 0 || md == 3) begin
            m_ph[i] = PH_STATIC; m_duty[i] = sd; m_step[i] = 0; m_hold[i] = 0;
            return;
        end
        saw = (md == 2);
        if (m_ph[i] == PH_IDLE || m_ph[i] == PH_STATIC) begin
            m_ph[i] = PH_UP; m_dir[i] = 1; m_step[i] = 0; m_hold[i] = 0;
            if (m_duty[i] < p_min[i]) m_duty[i] = p_min[i];
            if (m_duty[i] > p_max[i]) m_duty[i] = p_max[i];
        end else if (saw && m_ph[i] != PH_UP) begin
            m_ph[i] = PH_UP; m_dir[i] = 1; m_hold[i] = 0;
        end
        if (m_ph[i] == PH_TOP || m_ph[i] == PH_BOT) begin
            if (m_hold[i] < p_hold[i]) begin
                m_hold[i]++;
                return;
            end
            m_hold[i] = 0;
            if (m_ph[i] == PH_TOP) begin m_ph[i] = PH_DOWN; m_dir[i] = 0; end
            else begin m_ph[i] = PH_UP; m_dir[i] = 1; m_cd[i] = 1; end
        end
        step_due = (m_step[i] + 1 >= p_step[i]);
        if (m_ph[i] == PH_UP && saw) begin
            if (!step_due) m_step[i]++;
            else begin
                m_step[i] = 0;
                if (m_duty[i] >= p_max[i]) begin m_duty[i] = p_min[i]; m_cd[i] = 1; end
                else m_duty[i]++;
            end
        end else if (m_ph[i] == PH_UP) begin
            if (m_duty[i] >= p_max[i]) at_top(i);
            else if (!step_due) m_step[i]++;
            else begin
                m_step[i] = 0; m_duty[i]++;
                if (m_duty[i] == p_max[i]) at_top(i);
            end
        end else if (m_ph[i] == PH_DOWN) begin
            if (m_duty[i] <= p_min[i]) at_bottom(i);
            else if (!step_due) m_step[i]++;
            else begin
                m_step[i] = 0; m_duty[i]--;
                if (m_duty[i] == p_min[i]) at_bottom(i);
            end
        end
    endfunction

    function automatic void model_edge(int i, bit rst, bit en, int md, int sd);
        if (rst) begin
            m_ph[i] = PH_IDLE; m_duty[i] = 0; m_frame[i] = 0; m_step[i] = 0; m_hold[i] = 0;
            m_dir[i] = 1; m_fs[i] = 0; m_cd[i] = 0;
        end else if (!en) begin
            m_fs[i] = 0; m_cd[i] = 0;
        end else begin
            m_cd[i] = 0;
            m_fs[i] = (m_frame[i] == 15) ? 1 : 0;
            if (m_frame[i] == 15) model_frame(i, md, sd);
            m_frame[i] = (m_frame[i] + 1) % 16;
        end
    endfunction

    task automatic step_clk();
        @(posedge clk_3125KHz);
        for (int i = 0; i < NI; i++) model_edge(i, reset, enable, int'(mode), int'(static_duty));
        #1;
    endtask

    task automatic do_reset(int n);
        reset = 1'b1;
        enable = 1'b0;
        repeat (n) step_clk();
        reset = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_reset();
        mode = 2'b00; static_duty = 4'd9;
        do_reset(3);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if ({duty[i], fs[i], dir[i], cd[i]} !== {4'd0, 1'b0, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL reset inst=%0d got duty=%0d fs=%b dir=%b cd=%b want 0/0/1/0", i, duty[i], fs[i], dir[i], cd[i]);
            end
        end
    endtask

    task automatic test_static();
        logic [3:0] want_d;
        logic want_fs;
        mode = 2'b00; static_duty = 4'd9;
        do_reset(3);
        for (int k = 0; k < 64; k++) begin
            want_d  = (k < 16) ? 4'd0 : 4'd9;
            want_fs = (k == 16 || k == 32 || k == 48);
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (duty[i] !== want_d || fs[i] !== want_fs) begin
                    errors++;
                    $display("FAIL static k=%0d inst=%0d got duty=%0d fs=%b want duty=%0d fs=%b", k, i, duty[i], fs[i], want_d, want_fs);
                end
            end
            step_clk();
        end
    endtask

    task automatic test_triangle();
        int f;
        logic want_dir;
        mode = 2'b01;
        do_reset(1);
        for (int k = 0; k < 192; k++) begin
            f = k / 16;
            want_dir = (f >= 6 && f <= 10) ? 1'b0 : 1'b1;
            checks++;
            if (duty[0] !== 4'(tri_tab[f]) || dir[0] !== want_dir || cd[0] !== (k == 176)
                || fs[0] !== (k > 0 && k % 16 == 0)) begin
                errors++;
                $display("FAIL triangle k=%0d got duty=%0d dir=%b cd=%b fs=%b want duty=%0d dir=%b cd=%b",
                         k, duty[0], dir[0], cd[0], fs[0], tri_tab[f], want_dir, (k == 176));
            end
            step_clk();
        end
    endtask

    task automatic test_sawtooth();
        int f;
        mode = 2'b10;
        do_reset(1);
        for (int k = 0; k < 144; k++) begin
            f = k / 16;
            checks++;
            if (duty[1] !== 4'(saw_tab[f]) || cd[1] !== (k == 96) || dir[1] !== 1'b1) begin
                errors++;
                $display("FAIL sawtooth k=%0d got duty=%0d cd=%b dir=%b want duty=%0d cd=%b dir=1",
                         k, duty[1], cd[1], dir[1], saw_tab[f], (k == 96));
            end
            step_clk();
        end
    endtask

    task automatic test_mode_change();
        logic [3:0] want_d;
        mode = 2'b01;
        do_reset(1);
        repeat (39) step_clk();
        mode = 2'b00; static_duty = 4'd5;
        for (int k = 39; k < 64; k++) begin
            want_d = (k < 48) ? 4'd2 : 4'd5;
            checks++;
            if (duty[0] !== want_d) begin
                errors++;
                $display("FAIL mode_change k=%0d got duty=%0d want %0d", k, duty[0], want_d);
            end
            step_clk();
        end
    endtask

    task automatic test_enable_freeze();
        int  e = 0;
        bit  last_frozen = 0;
        bit  en;
        logic want_fs;
        mode = 2'b01;
        do_reset(1);
        for (int k = 0; k < 160; k++) begin
            want_fs = last_frozen ? 1'b0 : (e > 0 && e % 16 == 0);
            checks++;
            if (duty[0] !== 4'(tri_tab[e / 16]) || fs[0] !== want_fs || cd[0] !== 1'b0) begin
                errors++;
                $display("FAIL enable_freeze k=%0d e=%0d got duty=%0d fs=%b cd=%b want duty=%0d fs=%b cd=0",
                         k, e, duty[0], fs[0], cd[0], tri_tab[e / 16], want_fs);
            end
            en = !(k >= 37 && k < 57);
            enable = en;
            step_clk();
            if (en) e++;
            last_frozen = !en;
        end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid_ramp();
        mode = 2'b00; static_duty = 4'd15;
        do_reset(1);
        repeat (16) step_clk();
        mode = 2'b01;
        repeat (16) step_clk();
        checks++;
        if (duty[2] !== 4'd15 || dir[2] !== 1'b1) begin
            errors++;
            $display("FAIL hold_top_entry got duty=%0d dir=%b want 15/1", duty[2], dir[2]);
        end
        repeat (8) step_clk();
        reset = 1'b1;
        step_clk();
        reset = 1'b0;
        checks++;
        if ({duty[2], dir[2], fs[2], cd[2]} !== {4'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_ramp got duty=%0d dir=%b fs=%b cd=%b want 0/1/0/0", duty[2], dir[2], fs[2], cd[2]);
        end
        for (int k = 0; k < 144; k++) begin
            checks++;
            if (duty[2] !== 4'(k / 64)) begin
                errors++;
                $display("FAIL restart_ramp k=%0d got duty=%0d want %0d", k, duty[2], k / 64);
            end
            step_clk();
        end
    endtask

    task automatic test_random();
        mode = 2'b01;
        do_reset(2);
        for (int n = 0; n < 6000; n++) begin
            for (int i = 0; i < NI; i++) begin
                checks++;
                if ({duty[i], fs[i], dir[i], cd[i]} !== {4'(m_duty[i]), 1'(m_fs[i]), 1'(m_dir[i]), 1'(m_cd[i])}) begin
                    errors++;
                    $display("FAIL random n=%0d inst=%0d got duty=%0d fs=%b dir=%b cd=%b want duty=%0d fs=%0d dir=%0d cd=%0d",
                             n, i, duty[i], fs[i], dir[i], cd[i], m_duty[i], m_fs[i], m_dir[i], m_cd[i]);
                end
            end
            if ($urandom_range(0, 199) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) static_duty = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) enable = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 799) == 0);
            step_clk();
        end
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NI; i++) model_edge(i, 1'b1, 1'b0, 0, 0);
        test_reset();
        test_static();
        test_triangle();
        test_sawtooth();
        test_mode_change();
        test_enable_freeze();
        test_reset_mid_ramp();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
